// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode and funct codes, instruction class codes and the bit
// positions inside the 8-bit control bundle
// {illegal, jump, branch, mem_wr, mem_rd, alu_src, reg_dst, reg_wr}.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;

  typedef enum logic [2:0] {
    ClsR       = 3'd0,
    ClsIalu    = 3'd1,
    ClsLoad    = 3'd2,
    ClsStore   = 3'd3,
    ClsBranch  = 3'd4,
    ClsJump    = 3'd5,
    ClsIllegal = 3'd7
  } instr_class_e;

  // Control bundle bit indices
  localparam int unsigned CtrlRegWr   = 0;
  localparam int unsigned CtrlRegDst  = 1;
  localparam int unsigned CtrlAluSrc  = 2;
  localparam int unsigned CtrlMemRd   = 3;
  localparam int unsigned CtrlMemWr   = 4;
  localparam int unsigned CtrlBranch  = 5;
  localparam int unsigned CtrlJump    = 6;
  localparam int unsigned CtrlIllegal = 7;

  localparam logic [7:0] CtrlIllegalWord = 8'h80;

  // Opcodes whose immediate is zero-extended; every other form sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] opcode);
    return (opcode == OpAndi) || (opcode == OpOri);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational decode of one 32-bit MIPS instruction word.
//  instr_i    : instruction word
//  opcode_o.. : raw bit fields (opcode, rs, rt, rd, shamt, funct, 26-bit jump address)
//  imm_ext_o  : imm16 extended to DATA_WIDTH (zero-extended for andi/ori)
//  cls_o      : instruction class code
//  ctrl_o     : {illegal, jump, branch, mem_wr, mem_rd, alu_src, reg_dst, reg_wr}
module instr_field_decode
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [31:0]           instr_i,
  output logic [5:0]            opcode_o,
  output logic [4:0]            rs_o,
  output logic [4:0]            rt_o,
  output logic [4:0]            rd_o,
  output logic [4:0]            shamt_o,
  output logic [5:0]            funct_o,
  output logic [DATA_WIDTH-1:0] imm_ext_o,
  output logic [25:0]           address_o,
  output logic [2:0]            cls_o,
  output logic [7:0]            ctrl_o
);

  instr_class_e cls;
  logic [7:0]   ctrl;

  assign opcode_o  = instr_i[31:26];
  assign rs_o      = instr_i[25:21];
  assign rt_o      = instr_i[20:16];
  assign rd_o      = instr_i[15:11];
  assign shamt_o   = instr_i[10:6];
  assign funct_o   = instr_i[5:0];
  assign address_o = instr_i[25:0];

  assign imm_ext_o = is_zero_ext(instr_i[31:26]) ? DATA_WIDTH'(instr_i[15:0])
                                                 : DATA_WIDTH'($signed(instr_i[15:0]));

  always_comb begin
    cls  = ClsIllegal;
    ctrl = '0;
    case (instr_i[31:26])
      OpRtype: begin
        case (instr_i[5:0])
          FnSll, FnSrl, FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnSlt: begin
            cls = ClsR;
            // Writing $0 is a no-op, so the whole destination path is dropped; this keeps
            // the canonical nop (all zeros) at an all-zero control bundle.
            ctrl[CtrlRegWr]  = (instr_i[15:11] != 5'd0);
            ctrl[CtrlRegDst] = (instr_i[15:11] != 5'd0);
          end
          FnJr: begin
            cls            = ClsJump;
            ctrl[CtrlJump] = 1'b1;
          end
          default: ;
        endcase
      end
      OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpLui: begin
        cls              = ClsIalu;
        ctrl[CtrlAluSrc] = 1'b1;
        ctrl[CtrlRegWr]  = (instr_i[20:16] != 5'd0);
      end
      OpLw: begin
        cls              = ClsLoad;
        ctrl[CtrlMemRd]  = 1'b1;
        ctrl[CtrlAluSrc] = 1'b1;
        ctrl[CtrlRegWr]  = (instr_i[20:16] != 5'd0);
      end
      OpSw: begin
        cls              = ClsStore;
        ctrl[CtrlMemWr]  = 1'b1;
        ctrl[CtrlAluSrc] = 1'b1;
      end
      OpBeq, OpBne: begin
        cls              = ClsBranch;
        ctrl[CtrlBranch] = 1'b1;
      end
      OpJ: begin
        cls            = ClsJump;
        ctrl[CtrlJump] = 1'b1;
      end
      OpJal: begin
        // Link register is $31, so the write is never suppressed.
        cls             = ClsJump;
        ctrl[CtrlJump]  = 1'b1;
        ctrl[CtrlRegWr] = 1'b1;
      end
      default: ;
    endcase
    if (cls == ClsIllegal) begin
      ctrl = CtrlIllegalWord;
    end
  end

  assign cls_o  = cls;
  assign ctrl_o = ctrl;

endmodule

// File: rtl/instr_decode_stage.sv
// Pipelined MIPS decode stage between fetch and the register-file/ALU stage.
// The incoming word is decoded before the registers; the decoded bundle is held in entry A
// (drives the outputs) and, when SKID_EN=1, a second skid entry B.
//  clk, reset_n          : clock, asynchronous active-low reset
//  flush                 : drops both entries and any same-cycle input
//  in_valid/in_ready     : fetch-side handshake with in_instr, in_pc
//  out_valid/out_ready   : downstream handshake
//  out_opcode..out_ctrl  : registered decoded fields, pc, pc+4, class and control bundle
module instr_decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter bit          SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            out_opcode,
  output logic [4:0]            out_rs,
  output logic [4:0]            out_rt,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_shamt,
  output logic [5:0]            out_funct,
  output logic [DATA_WIDTH-1:0] out_imm_ext,
  output logic [25:0]           out_address,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [PC_WIDTH-1:0]   out_pc_plus4,
  output logic [2:0]            out_class,
  output logic [7:0]            out_ctrl
);

  typedef struct packed {
    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [25:0]           address;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [2:0]            cls;
    logic [7:0]            ctrl;
  } entry_t;

  logic [5:0]            dec_opcode;
  logic [4:0]            dec_rs;
  logic [4:0]            dec_rt;
  logic [4:0]            dec_rd;
  logic [4:0]            dec_shamt;
  logic [5:0]            dec_funct;
  logic [DATA_WIDTH-1:0] dec_imm_ext;
  logic [25:0]           dec_address;
  logic [2:0]            dec_cls;
  logic [7:0]            dec_ctrl;
  entry_t                dec;

  entry_t a_q, a_d, b_q, b_d;
  logic   a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic   accept, a_free;

  instr_field_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_field_decode (
    .instr_i   (in_instr),
    .opcode_o  (dec_opcode),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .rd_o      (dec_rd),
    .shamt_o   (dec_shamt),
    .funct_o   (dec_funct),
    .imm_ext_o (dec_imm_ext),
    .address_o (dec_address),
    .cls_o     (dec_cls),
    .ctrl_o    (dec_ctrl)
  );

  always_comb begin
    dec.opcode   = dec_opcode;
    dec.rs       = dec_rs;
    dec.rt       = dec_rt;
    dec.rd       = dec_rd;
    dec.shamt    = dec_shamt;
    dec.funct    = dec_funct;
    dec.imm_ext  = dec_imm_ext;
    dec.address  = dec_address;
    dec.pc       = in_pc;
    // pc+4 is stored rather than derived from out_pc so that it reads 0 out of reset.
    dec.pc_plus4 = in_pc + PC_WIDTH'(4);
    dec.cls      = dec_cls;
    dec.ctrl     = dec_ctrl;
  end

  // With the skid entry, in_ready depends only on state (B empty), breaking the ready path.
  assign in_ready = SKID_EN ? !b_valid_q : (!a_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign a_free   = !a_valid_q || out_ready;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else if (a_free) begin
      if (b_valid_q) begin
        // B is older than anything arriving now; in_ready was low so nothing is accepted.
        a_d       = b_q;
        a_valid_d = 1'b1;
        b_valid_d = 1'b0;
      end else if (accept) begin
        a_d       = dec;
        a_valid_d = 1'b1;
      end else begin
        a_valid_d = 1'b0;
      end
    end else if (accept) begin
      // A is stalled: park the new word in the skid entry (only reachable with SKID_EN=1).
      b_d       = dec;
      b_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign out_valid    = a_valid_q;
  assign out_opcode   = a_q.opcode;
  assign out_rs       = a_q.rs;
  assign out_rt       = a_q.rt;
  assign out_rd       = a_q.rd;
  assign out_shamt    = a_q.shamt;
  assign out_funct    = a_q.funct;
  assign out_imm_ext  = a_q.imm_ext;
  assign out_address  = a_q.address;
  assign out_pc       = a_q.pc;
  assign out_pc_plus4 = a_q.pc_plus4;
  assign out_class    = a_q.cls;
  assign out_ctrl     = a_q.ctrl;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  typedef logic [164:0] vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]  out_funct;
  logic [31:0] out_imm_ext;
  logic [25:0] out_address;
  logic [31:0] out_pc, out_pc_plus4;
  logic [2:0]  out_class;
  logic [7:0]  out_ctrl;

  int errors = 0;
  int checks = 0;
  vec_t mq[$];  // reference model: accepted, not yet delivered words (head = output)

  logic [5:0] op_list [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                               6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fn_list [10] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                               6'h25, 6'h2A};

  instr_decode_stage #(
    .DATA_WIDTH(32),
    .PC_WIDTH  (32),
    .SKID_EN   (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_funct   (out_funct),
    .out_imm_ext (out_imm_ext),
    .out_address (out_address),
    .out_pc      (out_pc),
    .out_pc_plus4(out_pc_plus4),
    .out_class   (out_class),
    .out_ctrl    (out_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  // Behavioural decode from the instruction-set rules.
  function automatic vec_t ref_decode(logic [31:0] w, logic [31:0] pc);
    int op, fn, rt, rd, imm, cls, ctrl;
    bit wr, dst, src, mrd, mwr, br, jmp;
    logic [31:0] immx;
    op = int'(w[31:26]); fn = int'(w[5:0]); rt = int'(w[20:16]); rd = int'(w[15:11]);
    imm = int'(w[15:0]);
    cls = 7; {wr, dst, src, mrd, mwr, br, jmp} = '0;
    if (op == 0) begin
      if (fn inside {0, 2, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h2A}) begin
        cls = 0; wr = (rd != 0); dst = (rd != 0);
      end else if (fn == 8) begin
        cls = 5; jmp = 1;
      end
    end else if (op inside {8, 9, 'hA, 'hC, 'hD, 'hF}) begin
      cls = 1; src = 1; wr = (rt != 0);
    end else if (op == 'h23) begin
      cls = 2; mrd = 1; src = 1; wr = (rt != 0);
    end else if (op == 'h2B) begin
      cls = 3; mwr = 1; src = 1;
    end else if (op == 4 || op == 5) begin
      cls = 4; br = 1;
    end else if (op == 2) begin
      cls = 5; jmp = 1;
    end else if (op == 3) begin
      cls = 5; jmp = 1; wr = 1;
    end
    ctrl = (cls == 7) ? 128 : int'(wr) + 2 * int'(dst) + 4 * int'(src) + 8 * int'(mrd)
                              + 16 * int'(mwr) + 32 * int'(br) + 64 * int'(jmp);
    if (op == 'hC || op == 'hD) immx = imm;
    else immx = (imm >= 32768) ? imm - 65536 : imm;
    return {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], immx, w[25:0], pc,
            pc + 32'd4, 3'(cls), 8'(ctrl)};
  endfunction

  function automatic vec_t observed();
    return {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm_ext, out_address,
            out_pc, out_pc_plus4, out_class, out_ctrl};
  endfunction

  // One clock edge; the model follows the same edge using the inputs as presented.
  task automatic tick();
    bit   pop, push, fl;
    vec_t nv;
    pop  = (mq.size() > 0) && out_ready;
    push = in_valid && (mq.size() < 2);
    fl   = flush;
    nv   = ref_decode(in_instr, in_pc);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(nv);
    end
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] w, logic [31:0] pc);
    in_valid = v; in_instr = w; in_pc = pc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    checks++;
    if (observed() !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", observed()); end
    reset_n = 1'b1;
    mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_nop();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0000, 32'h100);
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL nop_latency got=%b want=1", out_valid); end
    checks++;
    if ({out_opcode, out_funct, out_class, out_ctrl} !== 23'h0) begin
      errors++;
      $display("FAIL nop_decode got op=%h fn=%h cls=%0d ctrl=%h want all 0",
               out_opcode, out_funct, out_class, out_ctrl);
    end
    checks++;
    if (out_pc !== 32'h100 || out_pc_plus4 !== 32'h104) begin
      errors++; $display("FAIL nop_pc got=%h/%h want=00000100/00000104", out_pc, out_pc_plus4);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL nop_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_add_lw();
    out_ready = 1'b1;
    drive(1'b1, 32'h0178_2020, 32'h200);
    tick();
    checks++;
    if ({out_rs, out_rt, out_rd, out_shamt, out_funct} !== {5'd11, 5'd24, 5'd4, 5'd0, 6'h20}) begin
      errors++;
      $display("FAIL add_fields got rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want 11 24 4 0 20",
               out_rs, out_rt, out_rd, out_shamt, out_funct);
    end
    checks++;
    if (out_class !== 3'd0 || out_ctrl !== 8'h03) begin
      errors++; $display("FAIL add_ctrl got cls=%0d ctrl=%h want 0/03", out_class, out_ctrl);
    end
    // back-to-back: lw accepted on the very next edge
    drive(1'b1, 32'h8C88_0004, 32'h204);
    tick();
    checks++;
    if ({out_opcode, out_rs, out_rt, out_imm_ext} !== {6'h23, 5'd4, 5'd8, 32'h4}) begin
      errors++;
      $display("FAIL lw_fields got op=%h rs=%0d rt=%0d imm=%h want 23 4 8 00000004",
               out_opcode, out_rs, out_rt, out_imm_ext);
    end
    checks++;
    if (out_valid !== 1'b1 || out_class !== 3'd2 || out_ctrl !== 8'h0D) begin
      errors++;
      $display("FAIL lw_ctrl got v=%b cls=%0d ctrl=%h want 1/2/0d", out_valid, out_class, out_ctrl);
    end
  endtask

  task automatic test_imm_ext();
    out_ready = 1'b1;
    drive(1'b1, 32'h3408_FFFF, 32'hFFFF_FFFC);
    tick();
    checks++;
    if (out_imm_ext !== 32'h0000_FFFF || out_ctrl !== 8'h05 || out_class !== 3'd1) begin
      errors++;
      $display("FAIL ori_zext got imm=%h ctrl=%h cls=%0d want 0000ffff/05/1",
               out_imm_ext, out_ctrl, out_class);
    end
    checks++;
    if (out_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL pc_wrap got=%h want=00000000", out_pc_plus4);
    end
    drive(1'b1, 32'h2008_FFFF, 32'h300);
    tick();
    checks++;
    if (out_imm_ext !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL addi_sext got=%h want=ffffffff", out_imm_ext);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_skid_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h8C88_0004, 32'h400);  // w0 lw
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_rdy0 got=%b want=1", in_ready); end
    tick();
    drive(1'b1, 32'h0178_2020, 32'h404);  // w1 add
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_rdy1 got=%b want=1", in_ready); end
    tick();
    drive(1'b1, 32'h3408_FFFF, 32'h408);  // w2 ori, must be refused
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full got=%b want=0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h400) begin
      errors++;
      $display("FAIL skid_hold got rdy=%b v=%b pc=%h want 0/1/00000400", in_ready, out_valid, out_pc);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h404 || out_funct !== 6'h20) begin
      errors++; $display("FAIL skid_second got v=%b pc=%h want 1/00000404", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h408 || out_opcode !== 6'h0D) begin
      errors++; $display("FAIL skid_third got v=%b pc=%h want 1/00000408", out_valid, out_pc);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_flush_illegal();
    out_ready = 1'b0;
    drive(1'b1, 32'h0178_2020, 32'h500); tick();
    drive(1'b1, 32'h0178_2020, 32'h504); tick();
    flush = 1'b1;
    drive(1'b1, 32'h8C88_0004, 32'h508);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b want=0", out_valid); end
    out_ready = 1'b1;
    drive(1'b1, 32'hFC00_0000, 32'h600);
    tick();
    checks++;
    if (out_opcode !== 6'h3F || out_class !== 3'd7 || out_ctrl !== 8'h80) begin
      errors++;
      $display("FAIL illegal_op got op=%h cls=%0d ctrl=%h want 3f/7/80", out_opcode, out_class, out_ctrl);
    end
    drive(1'b1, 32'h0000_003F, 32'h604);
    tick();
    checks++;
    if (out_funct !== 6'h3F || out_class !== 3'd7 || out_ctrl !== 8'h80) begin
      errors++;
      $display("FAIL illegal_fn got fn=%h cls=%0d ctrl=%h want 3f/7/80", out_funct, out_class, out_ctrl);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (in_ready !== (mq.size() < 2)) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, in_ready, mq.size() < 2);
      end
      checks++;
      if (out_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, out_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        checks++;
        if (observed() !== mq[0]) begin
          errors++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, observed(), mq[0]);
        end
      end
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:26] = 6'h00;
        1: begin w[31:26] = 6'h00; w[5:0] = fn_list[$urandom_range(0, 9)]; end
        2: w[31:26] = op_list[$urandom_range(0, 12)];
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[20:11] = '0;  // exercise $0 destinations
      drive($urandom_range(0, 9) < 7, w, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 31) == 0;
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    drive(1'b1, 32'h0178_2020, 32'h700); tick();
    drive(1'b1, 32'h8C88_0004, 32'h704); tick();
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
      errors++;
      $display("FAIL rst_mid got v=%b rdy=%b data=%h want 0/1/0", out_valid, in_ready, observed());
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || observed() !== '0) begin
        errors++;
        $display("FAIL rst_quiet cyc=%0d got v=%b data=%h want 0/0", c, out_valid, observed());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_add_lw();
    test_imm_ext();
    test_skid_stall();
    test_flush_illegal();
    test_random();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
